execute_stage_mdu: RTL and testbench
====================================

// Module: execute_stage_mdu
// PURPOSE
//  Parametrised EX stage + EX/MEM pipeline register for the 5-stage RISC-V core.
//  Adds over the prior EX stage: full RV32I branch set, JAL/JALR target, SLT/shift ALU ops,
//  EX/MEM stall/bubble control, and an iterative M-extension unit that stalls the pipe while busy.
//  Sits between the ID/EX register and the memory stage; forwarding selects come from the hazard unit.
// PARAMETERS
//  XLEN    32  datapath width
//  RIDX    5   register-index width
//  MDU_EN  1   1 = M-extension present; 0 = md ops return 0 in 1 cycle (no busy)
// PORTS
//  clk            in   1     clock
//  rst            in   1     async reset, active-low
//  stall_m_i      in   1     hold EX/MEM register (downstream stall)
//  flush_e_i      in   1     kill instruction in E (branch flush / trap)
//  valid_e        in   1     E holds a real instruction
//  reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e, md_e  in 1  decoded controls
//  result_src_e   in   2     W-stage result select, passed through
//  br_funct3_e    in   3     branch condition
//  alu_ctrl_e     in   4     ALU op
//  md_op_e        in   3     M op: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU (000..111)
//  rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w  in XLEN  operands / W forward
//  rd_e           in   RIDX  destination
//  forward_a_e, forward_b_e  in 2  00 reg, 01 result_w, 10 alu_result_m, 11 = reg
//  pc_src_e       out  1     redirect fetch (combinational)
//  pc_target_e    out  XLEN  redirect target (combinational)
//  busy_e         out  1     MDU stall request to hazard unit (combinational)
//  valid_m, reg_write_m, mem_write_m  out 1;  result_src_m out 2;  rd_m out RIDX
//  pc_plus4_m, write_data_m, alu_result_m  out XLEN  registered EX/MEM outputs
// BEHAVIOUR
//  - Reset: all *_m outputs 0, MDU FSM IDLE, busy_e 0. Reset mid-MDU op aborts it, no result.
//  - src_a = fwd mux(a); src_b_raw = fwd mux(b); src_b = alu_src_e ? imm : src_b_raw;
//    write_data_m captures src_b_raw.
//  - ALU: ADD,SUB,AND,OR,XOR,SLT,SLTU,SLL,SRL,SRA; shift amount = src_b[$clog2(XLEN)-1:0].
//  - Branch cond on src_a/src_b_raw: 000 EQ,001 NE,100 LT,101 GE,110 LTU,111 GEU; 010/011 never taken.
//  - pc_target_e = jalr_e ? (src_a+imm)&~1 : pc_e+imm, mod 2^XLEN.
//  - pc_src_e = valid_e & ~flush_e_i & (jump_e | branch_e & cond).
//  - MDU FSM IDLE->BUSY->DONE. Cycle 0: valid_e&md_e in IDLE, operands captured at edge.
//    Cycles 1..XLEN: BUSY, one shift-add / restoring-divide step per cycle.
//    Cycle XLEN+1: DONE, result drives EX/MEM input.
//  - busy_e = valid_e & md_e & ~DONE, i.e. high XLEN+1 cycles. DONE->IDLE when ~stall_m_i, else hold.
//  - Fixed latency for every md op. Special results override the iterated value:
//    div by 0: DIV/DIVU = all-ones, REM/REMU = dividend. DIV(-2^(XLEN-1),-1) = dividend, REM = 0.
//    MULH* give the signed/unsigned high XLEN bits.
//  - EX/MEM update, priority: reset > stall_m_i (hold all) > bubble (valid_m/reg_write_m/mem_write_m = 0
//    when flush_e_i | busy_e | ~valid_e) > capture.
//  - flush_e_i in BUSY/DONE: FSM -> IDLE next cycle, busy_e drops combinationally, no result written.
//    flush_e_i with stall_m_i: M held, E killed.
// STRUCTURE
//  - exec_pkg: XLEN default, ALU op codes, md_op codes, branch funct3 codes, forward-select codes.
//  - Sub-module mdu_iterative: FSM, operand/sign capture, shift-add mul, restoring div, special cases.
//  - EX/MEM register stays in this module.
// TESTING
//  1. rd1=5, result_w=7, alu_result_m=9, fwd_a=10, ADD, alu_src=1, imm=1 -> next cycle alu_result_m=10, valid_m=1.
//  2. pc_e=0x100, imm=0x20, a=0xFFFFFFFF, b=1: BLT -> pc_src_e=1, target 0x120; BLTU -> pc_src_e=0.
//  3. JALR, src_a=0x1007, imm=4 -> pc_target_e=0x100A, pc_src_e=1; flush_e_i=1 same cycle -> pc_src_e=0.
//  4. MUL 6*7 -> busy_e high 33 cycles, alu_result_m=42 with valid_m=1 in cycle 34;
//     MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU -> 0xFFFFFFFE.
//  5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; all 33 busy cycles.
//  6. flush_e_i at cycle 10 of DIV -> busy_e 0, no valid_m; following ADD completes normally.
//     stall_m_i held 3 cycles in DONE -> result emitted once after release; rst low mid-MUL -> all *_m 0.

Source files
------------

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared widths, ALU/MDU/branch/forward codes and MDU state type for the EX stage
package exec_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RIDX_DEF = 5;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} mdu_state_t;

  function automatic logic md_signed_a(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_signed_b(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/execute_stage_mdu_if.sv
// rtl/execute_stage_mdu_if.sv - ID/EX inputs, hazard controls and EX/MEM outputs of the execute stage
interface execute_stage_mdu_if
  import exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RIDX = RIDX_DEF
);
  logic            stall_m_i, flush_e_i, valid_e;
  logic            reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e, md_e;
  logic [1:0]      result_src_e;
  logic [2:0]      br_funct3_e;
  logic [3:0]      alu_ctrl_e;
  logic [2:0]      md_op_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w;
  logic [RIDX-1:0] rd_e;
  logic [1:0]      forward_a_e, forward_b_e;

  logic            pc_src_e;
  logic [XLEN-1:0] pc_target_e;
  logic            busy_e;
  logic            valid_m, reg_write_m, mem_write_m;
  logic [1:0]      result_src_m;
  logic [RIDX-1:0] rd_m;
  logic [XLEN-1:0] pc_plus4_m, write_data_m, alu_result_m;

  modport master (
    output stall_m_i, flush_e_i, valid_e, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e,
           alu_src_e, md_e, result_src_e, br_funct3_e, alu_ctrl_e, md_op_e, rd1_e, rd2_e,
           imm_ext_e, pc_e, pc_plus4_e, result_w, rd_e, forward_a_e, forward_b_e,
    input  pc_src_e, pc_target_e, busy_e, valid_m, reg_write_m, mem_write_m, result_src_m,
           rd_m, pc_plus4_m, write_data_m, alu_result_m
  );

  modport slave (
    input  stall_m_i, flush_e_i, valid_e, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e,
           alu_src_e, md_e, result_src_e, br_funct3_e, alu_ctrl_e, md_op_e, rd1_e, rd2_e,
           imm_ext_e, pc_e, pc_plus4_e, result_w, rd_e, forward_a_e, forward_b_e,
    output pc_src_e, pc_target_e, busy_e, valid_m, reg_write_m, mem_write_m, result_src_m,
           rd_m, pc_plus4_m, write_data_m, alu_result_m
  );
endinterface

// File: rtl/execute_stage_mdu_mdu.sv
// rtl/execute_stage_mdu_mdu.sv - iterative multiply/divide unit, one shift-add or restoring step per cycle
module mdu_iterative
  import exec_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter bit MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic            stall,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  mdu_state_t      state, state_nx;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic [XLEN-1:0] acc_hi, acc_lo, opb, a_raw;
  logic            neg_q, neg_r, div_zero, ovf;
  logic            req, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   mul_sum, div_tmp, div_diff;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] quo, rem, res;

  assign req   = MDU_EN && start && !flush;
  assign busy  = req && (state != MDU_DONE);
  assign a_neg = md_signed_a(op_in) & a[XLEN-1];
  assign b_neg = md_signed_b(op_in) & b[XLEN-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  // acc_hi:acc_lo is the product for mul, remainder:quotient for div
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign div_tmp  = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff = div_tmp - {1'b0, opb};

  always_comb begin
    state_nx = state;
    case (state)
      MDU_IDLE: if (req) state_nx = MDU_BUSY;
      MDU_BUSY: begin
        if (!req)                      state_nx = MDU_IDLE;
        else if (cnt == CW'(XLEN - 1)) state_nx = MDU_DONE;
      end
      MDU_DONE: if (!req || !stall) state_nx = MDU_IDLE;
      default:  state_nx = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= MDU_IDLE;
      cnt      <= '0;
      op       <= MD_MUL;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      a_raw    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        MDU_IDLE: if (req) begin
          op       <= op_in;
          cnt      <= '0;
          acc_hi   <= '0;
          acc_lo   <= abs_a;
          opb      <= abs_b;
          a_raw    <= a;
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          div_zero <= (b == '0);
          ovf      <= md_signed_b(op_in) && op_in[2] &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
        end
        MDU_BUSY: begin
          cnt <= cnt + CW'(1);
          if (op[2]) begin
            acc_hi <= div_diff[XLEN] ? div_tmp[XLEN-1:0] : div_diff[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    res    = '0;
    prod_s = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo    = neg_q ? -acc_lo : acc_lo;
    rem    = neg_r ? -acc_hi : acc_hi;
    case (op)
      MD_MUL:                       res = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              res = div_zero ? '1 : (ovf ? a_raw : quo);
      default:                      res = div_zero ? a_raw : (ovf ? '0 : rem);
    endcase
  end

  assign result = (state == MDU_DONE) ? res : '0;

endmodule

// File: rtl/execute_stage_mdu.sv
// rtl/execute_stage_mdu.sv - RV32 execute stage: forwarding, ALU, branch/jump resolve, MDU and EX/MEM register
module execute_stage_mdu
  import exec_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int RIDX   = RIDX_DEF,
  parameter bit MDU_EN = 1'b1
) (
  input logic                clk,
  input logic                rst,
  execute_stage_mdu_if.slave ex
);
  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] src_a, src_b_raw, src_b, alu_res, md_result, ex_result;
  logic [SW-1:0]   shamt;
  logic            br_cond, bubble;

  always_comb begin
    src_a = ex.rd1_e;
    case (ex.forward_a_e)
      FWD_W:   src_a = ex.result_w;
      FWD_M:   src_a = ex.alu_result_m;
      default: src_a = ex.rd1_e;
    endcase
    src_b_raw = ex.rd2_e;
    case (ex.forward_b_e)
      FWD_W:   src_b_raw = ex.result_w;
      FWD_M:   src_b_raw = ex.alu_result_m;
      default: src_b_raw = ex.rd2_e;
    endcase
  end

  assign src_b = ex.alu_src_e ? ex.imm_ext_e : src_b_raw;
  assign shamt = src_b[SW-1:0];

  always_comb begin
    alu_res = src_a + src_b;
    case (ex.alu_ctrl_e)
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_res = src_a << shamt;
      ALU_SRL:  alu_res = src_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      default:  alu_res = src_a + src_b;
    endcase
  end

  // Branches compare the register operands, never the immediate
  always_comb begin
    br_cond = 1'b0;
    case (ex.br_funct3_e)
      BR_EQ:   br_cond = (src_a == src_b_raw);
      BR_NE:   br_cond = (src_a != src_b_raw);
      BR_LT:   br_cond = ($signed(src_a) < $signed(src_b_raw));
      BR_GE:   br_cond = ($signed(src_a) >= $signed(src_b_raw));
      BR_LTU:  br_cond = (src_a < src_b_raw);
      BR_GEU:  br_cond = (src_a >= src_b_raw);
      default: br_cond = 1'b0;
    endcase
  end

  assign ex.pc_target_e = ex.jalr_e ? ((src_a + ex.imm_ext_e) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                    : (ex.pc_e + ex.imm_ext_e);
  assign ex.pc_src_e = ex.valid_e & ~ex.flush_e_i & (ex.jump_e | (ex.branch_e & br_cond));

  mdu_iterative #(.XLEN(XLEN), .MDU_EN(MDU_EN)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (ex.valid_e & ex.md_e),
    .flush  (ex.flush_e_i),
    .stall  (ex.stall_m_i),
    .op_in  (ex.md_op_e),
    .a      (src_a),
    .b      (src_b_raw),
    .busy   (ex.busy_e),
    .result (md_result)
  );

  assign ex_result = ex.md_e ? md_result : alu_res;
  assign bubble    = ex.flush_e_i | ex.busy_e | ~ex.valid_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex.valid_m      <= 1'b0;
      ex.reg_write_m  <= 1'b0;
      ex.mem_write_m  <= 1'b0;
      ex.result_src_m <= 2'b00;
      ex.rd_m         <= {RIDX{1'b0}};
      ex.pc_plus4_m   <= '0;
      ex.write_data_m <= '0;
      ex.alu_result_m <= '0;
    end else if (!ex.stall_m_i) begin
      ex.valid_m      <= ~bubble;
      ex.reg_write_m  <= ex.reg_write_e & ~bubble;
      ex.mem_write_m  <= ex.mem_write_e & ~bubble;
      ex.result_src_m <= ex.result_src_e;
      ex.rd_m         <= ex.rd_e;
      ex.pc_plus4_m   <= ex.pc_plus4_e;
      ex.write_data_m <= src_b_raw;
      ex.alu_result_m <= ex_result;
    end
  end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// tb/tb_execute_stage_mdu.sv - scoreboard bench for the execute stage with iterative MDU
module tb_execute_stage_mdu;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_stage_mdu_if #(.XLEN(32), .RIDX(5)) ex_if ();

  execute_stage_mdu #(.XLEN(32), .RIDX(5), .MDU_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (ex_if)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [31:0] wd;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stall_cyc;
  } md_vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic stalled_last = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) stalled_last <= ex_if.stall_m_i;

  // Every freshly captured valid EX/MEM entry must match the oldest expectation
  always @(negedge clk) begin
    if (rst && ex_if.valid_m && !stalled_last) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid_m", 64'(ex_if.alu_result_m), 64'hDEAD_0000_0000_0000);
      end else begin
        mon_e = sb.pop_front();
        check_eq("alu_result_m", 64'(ex_if.alu_result_m), 64'(mon_e.res));
        check_eq("rd_m", 64'(ex_if.rd_m), 64'(mon_e.rd));
        check_eq("write_data_m", 64'(ex_if.write_data_m), 64'(mon_e.wd));
        check_eq("reg_write_m", 64'(ex_if.reg_write_m), 64'd1);
      end
    end
  end

  task automatic set_idle();
    ex_if.flush_e_i    = 1'b0;
    ex_if.valid_e      = 1'b0;
    ex_if.reg_write_e  = 1'b0;
    ex_if.mem_write_e  = 1'b0;
    ex_if.branch_e     = 1'b0;
    ex_if.jump_e       = 1'b0;
    ex_if.jalr_e       = 1'b0;
    ex_if.alu_src_e    = 1'b0;
    ex_if.md_e         = 1'b0;
    ex_if.result_src_e = 2'b00;
    ex_if.br_funct3_e  = 3'b010;
    ex_if.alu_ctrl_e   = ALU_ADD;
    ex_if.md_op_e      = MD_MUL;
    ex_if.rd1_e        = '0;
    ex_if.rd2_e        = '0;
    ex_if.imm_ext_e    = '0;
    ex_if.pc_e         = '0;
    ex_if.pc_plus4_e   = '0;
    ex_if.rd_e         = '0;
    ex_if.forward_a_e  = FWD_REG;
    ex_if.forward_b_e  = FWD_REG;
  endtask

  task automatic alu_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic use_imm, input logic [1:0] fa,
                           input logic [1:0] fb, input logic [4:0] rd, input logic [31:0] exp_res,
                           input logic [31:0] exp_wd);
    ex_if.valid_e     = 1'b1;
    ex_if.reg_write_e = 1'b1;
    ex_if.md_e        = 1'b0;
    ex_if.alu_ctrl_e  = op;
    ex_if.rd1_e       = a;
    ex_if.rd2_e       = b;
    ex_if.imm_ext_e   = imm;
    ex_if.alu_src_e   = use_imm;
    ex_if.forward_a_e = fa;
    ex_if.forward_b_e = fb;
    ex_if.rd_e        = rd;
    sb.push_back('{exp_res, rd, exp_wd});
    @(posedge clk);
    #1;
  endtask

  task automatic md_drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    ex_if.valid_e     = 1'b1;
    ex_if.reg_write_e = 1'b1;
    ex_if.md_e        = 1'b1;
    ex_if.md_op_e     = op;
    ex_if.rd1_e       = a;
    ex_if.rd2_e       = b;
    ex_if.alu_src_e   = 1'b0;
    ex_if.forward_a_e = FWD_REG;
    ex_if.forward_b_e = FWD_REG;
    ex_if.rd_e        = rd;
  endtask

  task automatic md_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int stall_cyc);
    int n;
    md_drive(op, a, b, rd);
    sb.push_back('{exp_res, rd, b});
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ex_if.busy_e) break;
      n++;
    end
    check_eq("md_busy_cycles", 64'(n), 64'd33);
    if (stall_cyc > 0) begin
      ex_if.stall_m_i = 1'b1;
      repeat (stall_cyc) @(posedge clk);
      #1;
      ex_if.stall_m_i = 1'b0;
      @(negedge clk);
      check_eq("busy_in_held_done", 64'(ex_if.busy_e), 64'd0);
    end
    @(posedge clk);
    #1;
    set_idle();
  endtask

  alu_vec_t alu_tbl[9] = '{
    '{ALU_SUB,  32'd10,        32'd3,         32'd7},
    '{ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000},
    '{ALU_OR,   32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF},
    '{ALU_SLT,  32'hFFFF_FFFB, 32'd3,         32'd1},
    '{ALU_SLT,  32'd3,         32'hFFFF_FFFB, 32'd0},
    '{ALU_SLTU, 32'hFFFF_FFFB, 32'd3,         32'd0},
    '{ALU_SLL,  32'd1,         32'h0000_0024, 32'd16},
    '{ALU_SRL,  32'h8000_0000, 32'd31,        32'd1},
    '{ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000}
  };

  md_vec_t md_tbl[15] = '{
    '{MD_MUL,    32'd6,         32'd7,         32'd42,        0},
    '{MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         0},
    '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0},
    '{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0},
    '{MD_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 0},
    '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0},
    '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0},
    '{MD_DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF, 0},
    '{MD_REMU,   32'd7,         32'd0,         32'd7,         0},
    '{MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0},
    '{MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0},
    '{MD_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 0},
    '{MD_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0},
    '{MD_DIVU,   32'd100,       32'd7,         32'd14,        0},
    '{MD_MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, 3}
  };

  task automatic br_step(input logic [2:0] f3, input logic exp_src, input string tag);
    ex_if.br_funct3_e = f3;
    @(negedge clk);
    check_eq(tag, 64'(ex_if.pc_src_e), 64'(exp_src));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ex_if.stall_m_i = 1'b0;
    ex_if.result_w  = '0;
    set_idle();
    repeat (2) @(negedge clk);
    check_eq("rst_valid_m", 64'(ex_if.valid_m), 64'd0);
    check_eq("rst_alu_result_m", 64'(ex_if.alu_result_m), 64'd0);
    check_eq("rst_busy_e", 64'(ex_if.busy_e), 64'd0);
    check_eq("rst_rd_m", 64'(ex_if.rd_m), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // forwarding from M, W and the reg/11 encodings
    ex_if.result_w = 32'd7;
    alu_issue(ALU_ADD, 32'd4,    32'd0,    32'd5, 1'b1, FWD_REG, FWD_REG, 5'd1, 32'd9,    32'd0);
    alu_issue(ALU_ADD, 32'd5,    32'd0,    32'd1, 1'b1, FWD_M,   FWD_REG, 5'd2, 32'd10,   32'd0);
    alu_issue(ALU_ADD, 32'd5,    32'd0,    32'd1, 1'b1, FWD_W,   FWD_REG, 5'd3, 32'd8,    32'd0);
    alu_issue(ALU_SUB, 32'd20,   32'd3,    32'd0, 1'b0, FWD_REG, FWD_W,   5'd4, 32'd13,   32'd7);
    alu_issue(ALU_XOR, 32'h00F0, 32'h000F, 32'd0, 1'b0, FWD_REG, 2'b11,   5'd5, 32'h00FF, 32'h000F);
    for (int i = 0; i < 9; i++)
      alu_issue(alu_tbl[i].op, alu_tbl[i].a, alu_tbl[i].b, 32'd0, 1'b0, FWD_REG, FWD_REG,
                5'(i + 8), alu_tbl[i].exp, alu_tbl[i].b);

    // branch/jump resolution with M frozen so nothing is captured
    ex_if.stall_m_i   = 1'b1;
    ex_if.valid_e     = 1'b1;
    ex_if.reg_write_e = 1'b0;
    ex_if.branch_e    = 1'b1;
    ex_if.rd1_e       = 32'hFFFF_FFFF;
    ex_if.rd2_e       = 32'd1;
    ex_if.pc_e        = 32'h100;
    ex_if.imm_ext_e   = 32'h20;
    br_step(BR_LT, 1'b1, "blt_taken");
    check_eq("br_target", 64'(ex_if.pc_target_e), 64'h120);
    br_step(BR_LTU, 1'b0, "bltu_not_taken");
    br_step(BR_GE,  1'b0, "bge_not_taken");
    br_step(BR_GEU, 1'b1, "bgeu_taken");
    br_step(BR_NE,  1'b1, "bne_taken");
    br_step(BR_EQ,  1'b0, "beq_not_taken");
    br_step(3'b010, 1'b0, "f3_010_never");
    ex_if.rd2_e = 32'hFFFF_FFFF;
    br_step(BR_EQ,  1'b1, "beq_taken");
    br_step(3'b011, 1'b0, "f3_011_never");
    check_eq("stall_hold_valid_m", 64'(ex_if.valid_m), 64'd1);
    check_eq("stall_hold_result", 64'(ex_if.alu_result_m), 64'(alu_tbl[8].exp));
    ex_if.branch_e  = 1'b0;
    ex_if.jump_e    = 1'b1;
    ex_if.jalr_e    = 1'b1;
    ex_if.rd1_e     = 32'h1007;
    ex_if.imm_ext_e = 32'd4;
    @(negedge clk);
    check_eq("jalr_target", 64'(ex_if.pc_target_e), 64'h100A);
    check_eq("jalr_pc_src", 64'(ex_if.pc_src_e), 64'd1);
    ex_if.flush_e_i = 1'b1;
    @(negedge clk);
    check_eq("jalr_flushed", 64'(ex_if.pc_src_e), 64'd0);
    ex_if.flush_e_i = 1'b0;
    ex_if.jalr_e    = 1'b0;
    ex_if.imm_ext_e = 32'hFFFF_FFF0;
    @(negedge clk);
    check_eq("jal_target", 64'(ex_if.pc_target_e), 64'hF0);
    ex_if.valid_e = 1'b0;
    @(negedge clk);
    check_eq("jal_invalid", 64'(ex_if.pc_src_e), 64'd0);
    set_idle();
    @(posedge clk);
    #1;
    ex_if.stall_m_i = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++)
      md_issue(md_tbl[i].op, md_tbl[i].a, md_tbl[i].b, 5'(i + 1), md_tbl[i].exp,
               md_tbl[i].stall_cyc);

    // flush part-way through a divide
    md_drive(MD_DIV, 32'd100, 32'd7, 5'd20);
    repeat (10) @(negedge clk);
    check_eq("div_busy_before_flush", 64'(ex_if.busy_e), 64'd1);
    ex_if.flush_e_i = 1'b1;
    #1;
    check_eq("flush_busy_drop", 64'(ex_if.busy_e), 64'd0);
    @(posedge clk);
    #1;
    set_idle();
    alu_issue(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, FWD_REG, FWD_REG, 5'd21, 32'd3, 32'd2);
    set_idle();
    md_issue(MD_REMU, 32'd100, 32'd7, 5'd22, 32'd2, 0);

    // reset in the middle of a multiply
    md_drive(MD_MUL, 32'd3, 32'd5, 5'd9);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rstmid_valid_m", 64'(ex_if.valid_m), 64'd0);
    check_eq("rstmid_write_data_m", 64'(ex_if.write_data_m), 64'd0);
    check_eq("rstmid_rd_m", 64'(ex_if.rd_m), 64'd0);
    check_eq("rstmid_alu_result_m", 64'(ex_if.alu_result_m), 64'd0);
    check_eq("rstmid_reg_write_m", 64'(ex_if.reg_write_m), 64'd0);
    set_idle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    md_issue(MD_MUL, 32'd6, 32'd7, 5'd23, 32'd42, 0);

    repeat (3) @(negedge clk);
    check_eq("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
